// File: rtl/fir_mac_sequencer.sv
// Single-MAC FIR filter: one accepted sample triggers NTAPS multiply-accumulate cycles over a circular delay line.
// Optional macro FIR_MAC_SEQUENCER_SATURATE_EN clamps the output; otherwise the output wraps in two's complement.
module fir_mac_sequencer #(
   parameter int NTAPS      = 13,
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(NTAPS)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             sample_valid,
   input  logic signed [DATA_WIDTH-1:0]     sample_in,
   output logic        [$clog2(NTAPS)-1:0]  coef_addr,
   input  logic signed [DATA_WIDTH-1:0]     coef_data,
   output logic                             result_valid,
   output logic signed [DATA_WIDTH-1:0]     result,
   output logic                             busy,
   output logic                             overrun,
   input  logic                             overrun_clr
);
   localparam int AW = $clog2(NTAPS);
   localparam int PW = 2*DATA_WIDTH;
   localparam logic [AW-1:0] LAST_IDX = AW'(NTAPS-1);
   localparam logic [AW-1:0] ZERO_IDX = {AW{1'b0}};
   localparam logic [AW-1:0] ONE_IDX  = AW'(1'b1);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_MAC = 1'b1} state_t;

   state_t                        r_state;
   state_t                        w_state_next;
   logic signed [DATA_WIDTH-1:0]  r_line [NTAPS];
   logic        [AW-1:0]          r_head;
   logic        [AW-1:0]          r_rd;
   logic        [AW-1:0]          r_tap;
   logic signed [ACC_WIDTH-1:0]   r_acc;
   logic signed [DATA_WIDTH-1:0]  r_result;
   logic                          r_result_valid;
   logic                          r_overrun;

   logic                          w_accept;
   logic                          w_drop;
   logic                          w_last;
   logic signed [PW-1:0]          w_prod;
   logic signed [ACC_WIDTH-1:0]   w_acc_sum;

`ifdef FIR_MAC_SEQUENCER_SATURATE_EN
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((32'sd1 <<< (DATA_WIDTH-1)) - 32'sd1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(32'sd1 <<< (DATA_WIDTH-1)));
`endif

   // Scale the Q1.(DATA_WIDTH-1) accumulation back to a sample and reduce it to DATA_WIDTH bits.
   function automatic logic signed [DATA_WIDTH-1:0] reduce_out(input logic signed [ACC_WIDTH-1:0] acc);
`ifdef FIR_MAC_SEQUENCER_SATURATE_EN
      logic signed [ACC_WIDTH-1:0] sh;
      sh = acc >>> (DATA_WIDTH-1);
      if (sh > SAT_MAX) begin
         return SAT_MAX[DATA_WIDTH-1:0];
      end else if (sh < SAT_MIN) begin
         return SAT_MIN[DATA_WIDTH-1:0];
      end else begin
         return sh[DATA_WIDTH-1:0];
      end
`else
      return acc[DATA_WIDTH-1 +: DATA_WIDTH];
`endif
   endfunction

   assign w_last    = (r_state == S_MAC) && (r_tap == LAST_IDX);
   assign w_prod    = $signed({{DATA_WIDTH{coef_data[DATA_WIDTH-1]}}, coef_data})
                    * $signed({{DATA_WIDTH{r_line[r_rd][DATA_WIDTH-1]}}, r_line[r_rd]});
   assign w_acc_sum = r_acc + $signed({{(ACC_WIDTH-PW){w_prod[PW-1]}}, w_prod});

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode plus sample accept/drop qualification.
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_drop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (sample_valid) begin
               w_accept     = 1'b1;
               w_state_next = S_MAC;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         S_MAC: begin
            w_drop = sample_valid;
            if (r_tap == LAST_IDX) begin
               w_state_next = S_IDLE;
            end else begin
               w_state_next = S_MAC;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Delay line, read pointer walking backwards from the newest sample, tap counter and accumulator.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NTAPS; i++) begin
            r_line[i] <= {DATA_WIDTH{1'b0}};
         end
         r_head         <= ZERO_IDX;
         r_rd           <= ZERO_IDX;
         r_tap          <= ZERO_IDX;
         r_acc          <= {ACC_WIDTH{1'b0}};
         r_result       <= {DATA_WIDTH{1'b0}};
         r_result_valid <= 1'b0;
      end else begin
         r_result_valid <= 1'b0;
         if (w_accept) begin
            r_line[r_head] <= sample_in;
            r_head         <= (r_head == LAST_IDX) ? ZERO_IDX : r_head + ONE_IDX;
            r_rd           <= r_head;
            r_tap          <= ZERO_IDX;
            r_acc          <= {ACC_WIDTH{1'b0}};
         end else if (r_state == S_MAC) begin
            r_acc <= w_acc_sum;
            r_rd  <= (r_rd == ZERO_IDX) ? LAST_IDX : r_rd - ONE_IDX;
            if (w_last) begin
               r_tap          <= ZERO_IDX;
               r_result       <= reduce_out(w_acc_sum);
               r_result_valid <= 1'b1;
            end else begin
               r_tap <= r_tap + ONE_IDX;
            end
         end
      end
   end

   // Sticky overrun: a drop in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_overrun <= 1'b0;
      end else if (w_drop) begin
         r_overrun <= 1'b1;
      end else if (overrun_clr) begin
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= r_overrun;
      end
   end

   assign coef_addr    = r_tap;
   assign busy         = (r_state == S_MAC);
   assign result       = r_result;
   assign result_valid = r_result_valid;
   assign overrun      = r_overrun;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Randomized scoreboard bench for fir_mac_sequencer; expectations come from a window-sum reference model.
module tb_fir_mac_sequencer;
   localparam int N  = 13;
   localparam int DW = 8;

   logic              clk;
   logic              reset;
   logic              sample_valid;
   logic signed [7:0] sample_in;
   logic        [3:0] coef_addr;
   logic signed [7:0] coef_data;
   logic              result_valid;
   logic signed [7:0] result;
   logic              busy;
   logic              overrun;
   logic              overrun_clr;

   logic signed [7:0] coef_mem [N];

   typedef struct {int val; int cyc;} exp_t;
   exp_t expq[$];
   int   hist[$];
   int   cyc, last_t, next_free;
   int   errors, checks;
   logic ovr_cur, ovr_next;
   int   exp_result;

   fir_mac_sequencer #(.NTAPS(N), .DATA_WIDTH(DW), .ACC_WIDTH(2*DW + 4)) dut (
      .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
      .coef_addr(coef_addr), .coef_data(coef_data), .result_valid(result_valid),
      .result(result), .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr)
   );

   assign coef_data = (coef_addr < 4'd13) ? coef_mem[coef_addr] : 8'sd0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, got, exp);
      end
   endfunction

   // y[n] = sum coef[k]*x[n-k] over the last N accepted samples, floor-scaled by 2^(DW-1), then reduced.
   function automatic int ref_out();
      longint acc;
      longint sh;
      int w;
      acc = 0;
      for (int k = 0; k < N; k++) begin
         if (k < hist.size()) acc += longint'(int'(coef_mem[k]) * hist[k]);
      end
      if (acc >= 0) sh = acc / 128;
      else          sh = -((-acc + 127) / 128);
`ifdef FIR_MAC_SEQUENCER_SATURATE_EN
      if (sh > 127)       w = 127;
      else if (sh < -128) w = -128;
      else                w = int'(sh);
`else
      w = int'(((sh % 256) + 256) % 256);
      if (w >= 128) w -= 256;
`endif
      return w;
   endfunction

   // Present one cycle of inputs, update the model for that cycle, then advance to the next cycle.
   task automatic drive(input logic v, input logic signed [7:0] s, input logic clr, input logic r);
      logic busy_now;
      reset = r; sample_valid = v; sample_in = s; overrun_clr = clr;
      busy_now = (cyc > last_t) && (cyc < next_free);
      if (r) begin
         hist.delete(); expq.delete();
         last_t = -100; next_free = 0; ovr_next = 1'b0; exp_result = 0;
      end else begin
         if (v && !busy_now) begin
            hist.push_front(int'(s));
            if (hist.size() > N) void'(hist.pop_back());
            expq.push_back('{val: ref_out(), cyc: cyc + N + 1});
            last_t = cyc; next_free = cyc + N + 1;
         end
         ovr_next = (v && busy_now) ? 1'b1 : (clr ? 1'b0 : ovr_cur);
      end
      @(posedge clk); #1;
      cyc++;
      ovr_cur = ovr_next;
   endtask

   task automatic send(input logic signed [7:0] s);
      while (cyc < next_free) drive(1'b0, 8'sd0, 1'b0, 1'b0);
      drive(1'b1, s, 1'b0, 1'b0);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < N + 3; i++) drive(1'b0, 8'sd0, 1'b0, 1'b0);
   endtask

   // Monitor: per-cycle control checks and scoreboard pop on every result strobe.
   always @(negedge clk) begin
      if (!reset) begin
         exp_t e;
         logic eb;
         eb = (cyc > last_t) && (cyc < next_free);
         while (expq.size() > 0 && expq[0].cyc < cyc) begin
            e = expq.pop_front();
            chk("missing_result_valid", 0, 1);
         end
         chk("busy", int'(busy), int'(eb));
         chk("coef_addr", int'(coef_addr), eb ? (cyc - last_t - 1) : 0);
         chk("overrun", int'(overrun), int'(ovr_cur));
         if (result_valid) begin
            if (expq.size() == 0) begin
               chk("unexpected_result_valid", 1, 0);
            end else begin
               e = expq.pop_front();
               chk("result", int'(result), e.val);
               chk("result_cycle", cyc, e.cyc);
               exp_result = e.val;
            end
         end else begin
            chk("result_hold", int'(result), exp_result);
         end
      end
   end

   initial begin
      int t0;
      reset = 1'b1; sample_valid = 1'b0; sample_in = 8'sd0; overrun_clr = 1'b0;
      cyc = 0; last_t = -100; next_free = 0; errors = 0; checks = 0;
      ovr_cur = 1'b0; ovr_next = 1'b0; exp_result = 0;
      for (int k = 0; k < N; k++) coef_mem[k] = 8'sd0;

      // Reset with sample_valid asserted: must be ignored.
      repeat (3) drive(1'b1, 8'sd55, 1'b0, 1'b1);

      // Impulse through tap 0.
      coef_mem[0] = 8'sd127;
      send(8'sd127);
      wait_idle();
      chk("impulse_result", int'(result), 126);

      // Impulse response with coef[k] = k+1.
      for (int k = 0; k < N; k++) coef_mem[k] = 8'(k + 1);
      send(8'sd127);
      for (int i = 0; i < N; i++) send(8'sd0);
      wait_idle();
      chk("impulse_tail_result", int'(result), 0);

      // Overrun: drop at T+5, then clear; then clear and drop together.
      send(8'sd40);
      repeat (4) drive(1'b0, 8'sd0, 1'b0, 1'b0);
      drive(1'b1, -8'sd99, 1'b0, 1'b0);
      wait_idle();
      drive(1'b0, 8'sd0, 1'b1, 1'b0);
      drive(1'b0, 8'sd0, 1'b0, 1'b0);
      send(8'sd10);
      drive(1'b1, 8'sd33, 1'b1, 1'b0);
      wait_idle();
      drive(1'b0, 8'sd0, 1'b1, 1'b0);

      // DC overflow: all coefficients 64, 13 samples of 100.
      for (int k = 0; k < N; k++) coef_mem[k] = 8'sd64;
      for (int i = 0; i < N; i++) send(8'sd100);
      wait_idle();
`ifdef FIR_MAC_SEQUENCER_SATURATE_EN
      chk("dc_result", int'(result), 127);
`else
      chk("dc_result", int'(result), -118);
`endif

      // Back-to-back with sample_valid held high and random data.
      for (int k = 0; k < N; k++) coef_mem[k] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 70; i++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      wait_idle();
      drive(1'b0, 8'sd0, 1'b1, 1'b0);

      // Reset at T+7 aborts the sequence; next impulse sees zero history.
      for (int k = 0; k < N; k++) coef_mem[k] = 8'sd100;
      send(8'sd50);
      t0 = cyc - 1;
      while (cyc < t0 + 7) drive(1'b0, 8'sd0, 1'b0, 1'b0);
      drive(1'b0, 8'sd0, 1'b0, 1'b1);
      drive(1'b0, 8'sd0, 1'b0, 1'b0);
      send(8'sd127);
      wait_idle();
      chk("post_reset_result", int'(result), 99);

      // Randomized traffic with occasional clears and resets.
      for (int k = 0; k < N; k++) coef_mem[k] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 1500; i++) begin
         drive(($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)),
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 299) == 0));
      end
      wait_idle();
      chk("scoreboard_empty", expq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
